video_grey: RTL and testbench
=============================

VIDEO_GREY -- requirements
Module: video_grey

Interface
REQ-001 SHALL have no parameters; widths are fixed by package constants: PIX_W=24, CH_W=8.
REQ-002 clk_i  input  1  pixel clock; all state on rising edge.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 enable_i  input  1  requests grey conversion (1) or pass-through (0); takes effect per frame only.
REQ-005 in_axis_tvalid  input  1  upstream pixel valid (from test-card generator).
REQ-006 in_axis_tready  output  1  block can accept a pixel this cycle.
REQ-007 in_axis_tdata  input  24  pixel: [23:16]=B, [15:8]=G, [7:0]=R.
REQ-008 in_axis_tuser  input  1  start-of-frame flag on the first pixel of a frame.
REQ-009 out_axis_tvalid  output  1  pixel valid to the downstream video encoder.
REQ-010 out_axis_tready  input  1  downstream accepts.
REQ-011 out_axis_tdata  output  24  converted or passed-through pixel, same channel order.
REQ-012 out_axis_tuser  output  1  start-of-frame, aligned with its pixel.

Function
REQ-013 A transfer SHALL occur on any edge where tvalid and tready are both 1; no pixel is dropped, duplicated or reordered.
REQ-014 The datapath SHALL be a 2-stage pipeline (S1: three products; S2: sum, round, replicate); latency from input transfer to out_axis_tvalid = 2 cycles when unstalled.
REQ-015 Grey: Y = (77*R + 150*G + 29*B + 128) >> 8, computed at 16 bits unsigned; out_axis_tdata = {Y,Y,Y}; Y max = 255, so no saturation is needed.
REQ-016 Pass-through mode SHALL output in_axis_tdata unchanged with the same 2-cycle latency.
REQ-017 Mode register SHALL load enable_i only on an input transfer with in_axis_tuser=1; that pixel and the rest of its frame use the new mode; the mode SHALL never change mid-frame.
REQ-018 tuser and the mode bit SHALL travel through the pipeline with their pixel.
REQ-019 Back-pressure: each stage advances when empty or when the next stage advances; in_axis_tready = !S1_valid | S1_advance; tready SHALL NOT depend combinationally on in_axis_tvalid.
REQ-020 When out_axis_tready=0 with both stages full, in_axis_tready SHALL be 0 and out_axis_tdata/tuser SHALL hold stable until accepted.
REQ-021 Bubbles (in_axis_tvalid=0) SHALL propagate as invalid stages; a full/empty pipeline SHALL sustain 1 pixel/cycle when out_axis_tready=1.
REQ-022 Simultaneous S2 output and S1 refill in one cycle SHALL be supported without a lost cycle.

Reset
REQ-023 On rst_n_i=0, asynchronously: out_axis_tvalid=0, out_axis_tdata=0, out_axis_tuser=0, all stage valids=0, mode=1 (grey).
REQ-024 in_axis_tready SHALL be 0 while rst_n_i=0 and 1 in the first cycle after release.
REQ-025 Reset mid-stream SHALL discard in-flight pixels; output restarts only from new input transfers.

Structure
REQ-026 Package video_pkg SHALL hold PIX_W, CH_W, COEF_R=77, COEF_G=150, COEF_B=29, ROUND=128 and a packed pixel typedef {b,g,r}.
REQ-027 One sub-module video_pipe_reg (valid/ready register slice with data+tuser+mode payload) SHALL be instantiated per stage.
REQ-028 The block SHALL sit between the test-card generator and the video encoder with no other glue.

Verification
REQ-029 Grey mode, tdata 0xFFFFFF, tuser=1 -> 2 cycles later out 0xFFFFFF, tuser=1.
REQ-030 Grey mode: 0x0000FF -> 0x4D4D4D; 0x00FF00 -> 0x959595; 0xFF0000 -> 0x1D1D1D; 0x000000 -> 0x000000.
REQ-031 Stream 100 random pixels with out_axis_tready low 5 cycles at pixel 10 -> in_axis_tready=0 after 2 accepted-but-held pixels; all 100 outputs match the model in order.
REQ-032 enable_i falls at pixel 50 of a frame -> pixels 50..end still grey; next tuser=1 pixel and onward pass through unchanged.
REQ-033 Assert rst_n_i with 2 pixels in flight -> out_axis_tvalid=0 same cycle, no stale pixel emitted after release, mode=grey.
REQ-034 Continuous valid/ready=1 for 1000 cycles -> exactly one output per cycle after the 2-cycle fill.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg -- shared widths, coefficients and payload types for the
// video_grey pixel pipeline.
//   pixel_t : packed pixel {b, g, r}, 8 bits per channel
//   s1_t    : stage-1 payload (original pixel + three weighted products)
//   s2_t    : stage-2 payload (original pixel + rounded luma)
package video_pkg;

  localparam int PIX_W  = 24;
  localparam int CH_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [CH_W-1:0]   COEF_R = 8'd77;
  localparam logic [CH_W-1:0]   COEF_G = 8'd150;
  localparam logic [CH_W-1:0]   COEF_B = 8'd29;
  localparam logic [PROD_W-1:0] ROUND  = 16'd128;

  typedef struct packed {
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
  } pixel_t;

  typedef struct packed {
    pixel_t            pix;
    logic [PROD_W-1:0] p_r;
    logic [PROD_W-1:0] p_g;
    logic [PROD_W-1:0] p_b;
  } s1_t;

  typedef struct packed {
    pixel_t          pix;
    logic [CH_W-1:0] y;
  } s2_t;

  localparam int S1_W = $bits(s1_t);
  localparam int S2_W = $bits(s2_t);

  // Largest product is 150*255 = 38250, so 16 bits never overflow.
  function automatic logic [PROD_W-1:0] mul_ch(input logic [CH_W-1:0] coef,
                                               input logic [CH_W-1:0] ch);
    return PROD_W'(coef) * PROD_W'(ch);
  endfunction

  // Coefficients sum to 256, so the rounded sum peaks at 65408 and the
  // upper byte is at most 255: no saturation stage is needed.
  function automatic logic [CH_W-1:0] grey_y(input logic [PROD_W-1:0] p_r,
                                             input logic [PROD_W-1:0] p_g,
                                             input logic [PROD_W-1:0] p_b);
    logic [PROD_W-1:0] sum;
    sum = p_r + p_g + p_b + ROUND;
    return CH_W'(sum >> CH_W);
  endfunction

endpackage

// File: rtl/video_pipe_reg.sv
// video_pipe_reg -- one valid/ready register slice carrying a data word plus
// the tuser and mode sideband bits of the pixel it holds.
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   i_valid / o_ready    : upstream handshake (o_ready = empty or draining)
//   i_data/i_user/i_mode : payload captured on an upstream transfer
//   o_valid / i_ready    : downstream handshake
//   o_data/o_user/o_mode : registered payload, held until accepted
module video_pipe_reg #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_user,
  input  logic         i_mode,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_user,
  output logic         o_mode
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_user;
  logic         r_mode;
  logic         w_load;

  // Ready depends only on local state and downstream ready, never on i_valid.
  assign o_ready = !r_valid | i_ready;
  assign w_load  = i_valid & o_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= 1'b0;
      r_mode  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_user  <= i_user;
      r_mode  <= i_mode;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_user  = r_user;
  assign o_mode  = r_mode;

endmodule

// File: rtl/video_grey.sv
// video_grey -- two-stage AXI-Stream pixel filter between the test-card
// generator and the video encoder. Converts RGB to replicated luma
// {Y,Y,Y} or passes pixels through unchanged; the mode is latched per frame.
//   clk_i, rst_n_i        : pixel clock, asynchronous active-low reset
//   enable_i              : 1 = grey, 0 = pass-through (sampled at frame start)
//   in_axis_*             : upstream stream, tdata = {B,G,R}, tuser = SOF
//   out_axis_*            : downstream stream, same layout, 2-cycle latency
module video_grey
  import video_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             in_axis_tvalid,
  output logic             in_axis_tready,
  input  logic [PIX_W-1:0] in_axis_tdata,
  input  logic             in_axis_tuser,
  output logic             out_axis_tvalid,
  input  logic             out_axis_tready,
  output logic [PIX_W-1:0] out_axis_tdata,
  output logic             out_axis_tuser
);

  logic            r_mode;
  pixel_t          w_in_pix;
  logic            w_in_xfer;
  logic            w_mode_in;
  s1_t             w_s1_in;
  s1_t             w_s1_out;
  logic [S1_W-1:0] w_s1_data;
  logic            w_s1_in_ready;
  logic            w_s1_valid;
  logic            w_s1_user;
  logic            w_s1_mode;
  s2_t             w_s2_in;
  s2_t             w_s2_out;
  logic [S2_W-1:0] w_s2_data;
  logic            w_s2_in_ready;
  logic            w_s2_mode;

  assign w_in_pix  = pixel_t'(in_axis_tdata);
  assign w_in_xfer = in_axis_tvalid & w_s1_in_ready;

  // The start-of-frame pixel already uses the newly sampled enable.
  assign w_mode_in = in_axis_tuser ? enable_i : r_mode;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode <= 1'b1;
    end else if (w_in_xfer && in_axis_tuser) begin
      r_mode <= enable_i;
    end
  end

  // Stage 1: weighted channel products.
  assign w_s1_in.pix = w_in_pix;
  assign w_s1_in.p_r = mul_ch(COEF_R, w_in_pix.r);
  assign w_s1_in.p_g = mul_ch(COEF_G, w_in_pix.g);
  assign w_s1_in.p_b = mul_ch(COEF_B, w_in_pix.b);

  video_pipe_reg #(.W(S1_W)) u_s1 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_valid (in_axis_tvalid),
    .o_ready (w_s1_in_ready),
    .i_data  (w_s1_in),
    .i_user  (in_axis_tuser),
    .i_mode  (w_mode_in),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_in_ready),
    .o_data  (w_s1_data),
    .o_user  (w_s1_user),
    .o_mode  (w_s1_mode)
  );

  assign w_s1_out = s1_t'(w_s1_data);

  // Stage 2: sum and round; the original pixel rides along for pass-through.
  assign w_s2_in.pix = w_s1_out.pix;
  assign w_s2_in.y   = grey_y(w_s1_out.p_r, w_s1_out.p_g, w_s1_out.p_b);

  video_pipe_reg #(.W(S2_W)) u_s2 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_in_ready),
    .i_data  (w_s2_in),
    .i_user  (w_s1_user),
    .i_mode  (w_s1_mode),
    .o_valid (out_axis_tvalid),
    .i_ready (out_axis_tready),
    .o_data  (w_s2_data),
    .o_user  (out_axis_tuser),
    .o_mode  (w_s2_mode)
  );

  assign w_s2_out = s2_t'(w_s2_data);

  // Select is a pure function of stage-2 registers, so the output is stable
  // while held under back-pressure and reads zero during reset.
  assign out_axis_tdata = w_s2_mode ? {3{w_s2_out.y}} : w_s2_out.pix;

  // Gated by reset so the upstream never sees ready while the block is held.
  assign in_axis_tready = rst_n_i & w_s1_in_ready;

endmodule

// File: tb/tb_video_grey.sv
module tb_video_grey;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic        in_axis_tvalid;
  logic        in_axis_tready;
  logic [23:0] in_axis_tdata;
  logic        in_axis_tuser;
  logic        out_axis_tvalid;
  logic        out_axis_tready;
  logic [23:0] out_axis_tdata;
  logic        out_axis_tuser;

  video_grey dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .enable_i        (enable_i),
    .in_axis_tvalid  (in_axis_tvalid),
    .in_axis_tready  (in_axis_tready),
    .in_axis_tdata   (in_axis_tdata),
    .in_axis_tuser   (in_axis_tuser),
    .out_axis_tvalid (out_axis_tvalid),
    .out_axis_tready (out_axis_tready),
    .out_axis_tdata  (out_axis_tdata),
    .out_axis_tuser  (out_axis_tuser)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] data;
    logic        user;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;
  bit   model_mode = 1'b1;

  always @(posedge clk_i) cyc = cyc + 1;

  // Reference: BT.601-style integer luma, replicated to all three channels.
  function automatic logic [23:0] ref_grey(input logic [23:0] p);
    int r, g, b, y;
    logic [7:0] yy;
    r  = int'(p[7:0]);
    g  = int'(p[15:8]);
    b  = int'(p[23:16]);
    y  = (77 * r + 150 * g + 29 * b + 128) / 256;
    yy = 8'(y);
    return {yy, yy, yy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk_i) begin
    if (rst_n_i && out_axis_tvalid && out_axis_tready) begin
      n_out++;
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        m_e = sb.pop_front();
        check("pixel", {7'b0, out_axis_tuser, out_axis_tdata}, {7'b0, m_e.user, m_e.data});
        if (m_e.chk_lat) check("latency", cyc - m_e.cyc, 2);
      end
    end
  end

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic drive(input bit v, input logic [23:0] d, input bit u, input bit en,
                       input bit otr, input bit use_exp, input logic [23:0] exp_d,
                       output bit acc);
    exp_t e;
    in_axis_tvalid  = v;
    in_axis_tdata   = d;
    in_axis_tuser   = u;
    enable_i        = en;
    out_axis_tready = otr;
    acc = 1'b0;
    @(negedge clk_i);
    if (in_axis_tvalid && in_axis_tready) begin
      acc = 1'b1;
      if (u) model_mode = en;
      e.data    = use_exp ? exp_d : (model_mode ? ref_grey(d) : d);
      e.user    = u;
      e.cyc     = cyc;
      e.chk_lat = lat_chk;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_exp(input logic [23:0] d, input bit u, input bit en, input bit otr,
                          input bit use_exp, input logic [23:0] exp_d);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) drive(1'b1, d, u, en, otr, use_exp, exp_d, acc);
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic send(input logic [23:0] d, input bit u, input bit en);
    send_exp(d, u, en, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) drive(1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) idle(1);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          n_acc;
    int          n_out0;
    logic [23:0] d;
    logic [24:0] held;

    rst_n_i         = 1'b0;
    enable_i        = 1'b1;
    in_axis_tvalid  = 1'b0;
    in_axis_tdata   = 24'h0;
    in_axis_tuser   = 1'b0;
    out_axis_tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_out_tvalid", out_axis_tvalid, 0);
    check("rst_out_tdata", out_axis_tdata, 0);
    check("rst_out_tuser", out_axis_tuser, 0);
    check("rst_in_tready", in_axis_tready, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("tready_after_release", in_axis_tready, 1);
    @(posedge clk_i);
    #1;

    // Directed grey values, latency 2
    lat_chk = 1'b1;
    send_exp(24'hFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    send_exp(24'h0000FF, 1'b0, 1'b1, 1'b1, 1'b1, 24'h4D4D4D);
    send_exp(24'h00FF00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h959595);
    send_exp(24'hFF0000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h1D1D1D);
    send_exp(24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
    idle(4);
    drain();

    // 100 random pixels, 5-cycle output stall at pixel 10
    lat_chk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      d = 24'($urandom);
      if (i == 10) begin
        in_axis_tvalid  = 1'b1;
        in_axis_tdata   = d;
        in_axis_tuser   = 1'b0;
        out_axis_tready = 1'b0;
        held = 25'h0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk_i);
          check("stall_in_tready", in_axis_tready, 0);
          check("stall_inflight", sb.size(), 2);
          check("stall_out_tvalid", out_axis_tvalid, 1);
          if (j == 0) begin
            held = {out_axis_tuser, out_axis_tdata};
            if (sb.size() != 0)
              check("stall_head", {7'b0, held}, {7'b0, sb[0].user, sb[0].data});
          end else begin
            check("stall_hold", {7'b0, out_axis_tuser, out_axis_tdata}, {7'b0, held});
          end
          @(posedge clk_i);
          #1;
        end
      end
      send(d, i == 0, 1'b1);
    end
    drain();

    // Random bubbles, back-pressure and per-frame mode changes
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
            1'($urandom), $urandom_range(0, 2) != 0, 1'b0, 24'h0, acc);
    end
    drain();

    // enable_i falls mid-frame: frame stays grey; next frame passes through
    lat_chk = 1'b1;
    for (int i = 0; i < 80; i++) send(24'($urandom), i == 0, i < 50);
    send_exp(24'h123456, 1'b1, 1'b0, 1'b1, 1'b1, 24'h123456);
    for (int i = 1; i < 30; i++) send(24'($urandom), 1'b0, (i % 2) == 0);
    send_exp(24'h0000FF, 1'b1, 1'b1, 1'b1, 1'b1, 24'h4D4D4D);
    drain();

    // Reset with two pixels in flight (output stalled)
    lat_chk = 1'b0;
    send_exp(24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    send_exp(24'h654321, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    in_axis_tvalid = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("midrst_out_tvalid", out_axis_tvalid, 0);
    check("midrst_out_tdata", out_axis_tdata, 0);
    check("midrst_in_tready", in_axis_tready, 0);
    sb.delete();
    model_mode = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    out_axis_tready = 1'b1;
    rst_n_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, acc);
      check("postrst_no_output", out_axis_tvalid, 0);
    end
    lat_chk = 1'b1;
    send_exp(24'h0000FF, 1'b0, 1'b0, 1'b1, 1'b1, 24'h4D4D4D);
    drain();

    // Sustained throughput: 1000 cycles of valid with ready held high
    idle(3);
    n_acc  = 0;
    n_out0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 24'($urandom), i == 0, 1'b1, 1'b1, 1'b0, 24'h0, acc);
      if (acc) n_acc++;
    end
    check("thru_accepted", n_acc, 1000);
    check("thru_outputs", n_out - n_out0, 998);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
